// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//    Raster timing generator for 640x480@60 Hz VGA (timing is parameterisable).
//    It produces the pixel position counters, the sync pulses, the visible-area
//    flag and a frame counter. Every output is a register, and all of them are
//    aligned with each other. Flags are computed from the *next* counter values,
//    so a flag always describes the same pixel as hpos/vpos in the same cycle.
//
// Ports:
//    clk        in   1   pixel clock
//    reset      in   1   asynchronous, active-high reset
//    hpos       out  10  horizontal position, 0..H_TOTAL-1
//    vpos       out  10  vertical position, 0..V_TOTAL-1
//    hsync      out  1   horizontal sync, asserted level = SYNC_POL
//    vsync      out  1   vertical sync, asserted level = SYNC_POL
//    display_on out  1   (hpos,vpos) lies inside the visible area
//    frame_tick out  1   high on the last pixel of every frame
//    frame_cnt  out  8   free-running frame counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] hpos,
   output logic [9:0] vpos,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic       frame_tick,
   output logic [7:0] frame_cnt
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   // The counters are 10 bits wide, so longer lines or frames cannot be counted.
   if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 2 || V_TOTAL < 2) begin : g_bad_params
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must lie in 2..1024");
   end

   // Window bounds are 11 bits wide. A bound may equal 1024 (e.g. H_DISPLAY
   // with zero porches), and that value must not alias to 0.
   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
   localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
   localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] HS_STOP  = 11'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
   localparam logic [10:0] VS_STOP  = 11'(V_DISPLAY + V_FRONT + V_SYNC);

   logic [9:0] hpos_reg, hpos_next;
   logic [9:0] vpos_reg, vpos_next;
   logic [7:0] frame_cnt_reg, frame_cnt_next;
   logic       hsync_reg, hsync_next;
   logic       vsync_reg, vsync_next;
   logic       display_on_reg, display_on_next;
   logic       frame_tick_reg, frame_tick_next;
   logic       line_wrap, frame_wrap;
   logic [10:0] hpos_ext, vpos_ext;

   always_comb begin
      line_wrap  = (hpos_reg == H_LAST);
      frame_wrap = line_wrap && (vpos_reg == V_LAST);

      hpos_next      = line_wrap ? 10'd0 : hpos_reg + 10'd1;
      vpos_next      = vpos_reg;
      frame_cnt_next = frame_cnt_reg;
      if (line_wrap) begin
         vpos_next = frame_wrap ? 10'd0 : vpos_reg + 10'd1;
      end
      if (frame_wrap) begin
         frame_cnt_next = frame_cnt_reg + 8'd1;
      end

      // Flags are decoded from the position the counters are about to take,
      // so after the edge they line up with hpos/vpos.
      hpos_ext = {1'b0, hpos_next};
      vpos_ext = {1'b0, vpos_next};

      hsync_next      = (hpos_ext >= HS_START && hpos_ext < HS_STOP) ? SYNC_POL : ~SYNC_POL;
      vsync_next      = (vpos_ext >= VS_START && vpos_ext < VS_STOP) ? SYNC_POL : ~SYNC_POL;
      display_on_next = (hpos_ext < H_VIS) && (vpos_ext < V_VIS);
      frame_tick_next = (hpos_next == H_LAST) && (vpos_next == V_LAST);
   end

   // The reset values describe pixel (0,0): it is visible and lies outside
   // both sync windows.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hpos_reg       <= 10'd0;
         vpos_reg       <= 10'd0;
         frame_cnt_reg  <= 8'd0;
         hsync_reg      <= ~SYNC_POL;
         vsync_reg      <= ~SYNC_POL;
         display_on_reg <= 1'b1;
         frame_tick_reg <= 1'b0;
      end else begin
         hpos_reg       <= hpos_next;
         vpos_reg       <= vpos_next;
         frame_cnt_reg  <= frame_cnt_next;
         hsync_reg      <= hsync_next;
         vsync_reg      <= vsync_next;
         display_on_reg <= display_on_next;
         frame_tick_reg <= frame_tick_next;
      end
   end

   assign hpos       = hpos_reg;
   assign vpos       = vpos_reg;
   assign hsync      = hsync_reg;
   assign vsync      = vsync_reg;
   assign display_on = display_on_reg;
   assign frame_tick = frame_tick_reg;
   assign frame_cnt  = frame_cnt_reg;

endmodule
